// File: rtl/rate_tick_counter_if.sv
// Control and display bus of the rate divider / display counter.
// master drives the controls, slave is the counter that returns tick/count/wrap.
interface rate_tick_counter_if #(
  parameter int COUNT_W = 4
) ();
  logic               enable;
  logic [1:0]         sel;
  logic               up_down;
  logic               load;
  logic [COUNT_W-1:0] load_val;
  logic               tick;
  logic [COUNT_W-1:0] count;
  logic               wrap;

  modport master (
    output enable, sel, up_down, load, load_val,
    input  tick, count, wrap
  );

  modport slave (
    input  enable, sel, up_down, load, load_val,
    output tick, count, wrap
  );
endinterface

// File: rtl/rate_tick_counter.sv
// Divides the board clock into one of four tick rates and advances a
// loadable up/down modulo counter on each tick; wrap cascades to the next digit.
module rate_tick_counter #(
  parameter int CLK_HZ    = 50000000,
  parameter int COUNT_W   = 4,
  parameter int COUNT_MAX = 15
) (
  input  logic clock,
  input  logic clear_b,
  rate_tick_counter_if.slave bus
);

  localparam int Q_W = $clog2(4 * CLK_HZ);
  localparam logic [Q_W-1:0]     P1_M1 = Q_W'(CLK_HZ - 1);
  localparam logic [Q_W-1:0]     P2_M1 = Q_W'(2 * CLK_HZ - 1);
  localparam logic [Q_W-1:0]     P4_M1 = Q_W'(4 * CLK_HZ - 1);
  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(COUNT_MAX);

  logic [Q_W-1:0]     q_reg, q_next;
  logic [1:0]         sel_q_reg, sel_q_next;
  logic               tick_reg, tick_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               wrap_reg, wrap_next;

  function automatic logic [Q_W-1:0] reload_of(input logic [1:0] s);
    case (s)
      2'd0:    return '0;
      2'd1:    return P1_M1;
      2'd2:    return P2_M1;
      default: return P4_M1;
    endcase
  endfunction

  // A rate change always wins, even while frozen, so the new period starts cleanly.
  always_comb begin
    q_next     = q_reg;
    sel_q_next = sel_q_reg;
    tick_next  = 1'b0;
    if (bus.sel != sel_q_reg) begin
      sel_q_next = bus.sel;
      q_next     = reload_of(bus.sel);
    end else if (bus.enable) begin
      if (q_reg == '0) begin
        q_next    = reload_of(sel_q_reg);
        tick_next = 1'b1;
      end else begin
        q_next = q_reg - Q_W'(1);
      end
    end
  end

  // The counter follows the tick decided on this same edge; load overrides it.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (bus.load) begin
      count_next = bus.load_val;
    end else if (tick_next) begin
      if (bus.up_down) begin
        if (count_reg >= MAX_C) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_reg + COUNT_W'(1);
        end
      end else begin
        if (count_reg == '0) begin
          count_next = MAX_C;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_reg - COUNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      q_reg     <= '0;
      sel_q_reg <= 2'd0;
      tick_reg  <= 1'b0;
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      q_reg     <= q_next;
      sel_q_reg <= sel_q_next;
      tick_reg  <= tick_next;
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign bus.tick  = tick_reg;
  assign bus.count = count_reg;
  assign bus.wrap  = wrap_reg;

endmodule
